// File: rtl/debug_ctrl_sender.sv
// Debug control-message sender: queues start/stop/kill commands and serialises them to the Messenger.
// Optional DBG_BCAST_EN: dest 4'hF is accepted and expanded to every core except SRC_ID.
module debug_ctrl_sender #(
  parameter int DEPTH  = 4,
  parameter int NCORES = 14,
  parameter int SRC_ID = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd_type,
  input  logic [3:0]  i_cmd_dest,
  output logic        o_cmd_ready,
  output logic        o_msg_valid,
  output logic [3:0]  o_msg_dest,
  output logic [3:0]  o_msg_src,
  output logic [3:0]  o_msg_type,
  input  logic        i_msg_accept,
  output logic        o_bad_cmd,
  output logic        o_idle,
  output logic [15:0] o_sent_count
);

  // state  | meaning
  // IDLE   | no message presented; pops the FIFO head when one exists
  // SEND   | single-target message presented, waiting for msgAccept
  // BCAST  | broadcast in progress, one target per accepted message
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LP_SRC = 4'(SRC_ID);
  localparam logic [4:0] LP_NC  = 5'(NCORES);

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef DBG_BCAST_EN
    ST_BCAST,
`endif
    ST_SEND
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [5:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [3:0]      r_msg_dest, w_dest_nxt;
  logic [1:0]      r_msg_type, w_type_nxt;
  logic            r_bad_cmd;
  logic [15:0]     r_sent_count;
  logic            w_full, w_empty, w_take, w_bad, w_push, w_pop, w_load, w_sent_inc;
  logic            w_bcast_legal;
  logic [5:0]      w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

`ifdef DBG_BCAST_EN
  localparam logic [3:0] LP_FIRST = (SRC_ID == 0) ? 4'd1 : 4'd0;
  logic [4:0] w_dest_inc, w_dest_step;
  logic       w_bcast_last;
  assign w_bcast_legal = (i_cmd_dest == 4'hF);
  assign w_dest_inc    = {1'b0, r_msg_dest} + 5'd1;
  assign w_dest_step   = (w_dest_inc == {1'b0, LP_SRC}) ? w_dest_inc + 5'd1 : w_dest_inc;
  assign w_bcast_last  = (w_dest_step >= LP_NC);
`else
  assign w_bcast_legal = 1'b0;
`endif

  assign w_take = i_cmd_valid & ~w_full;
  assign w_bad  = (i_cmd_type == 2'd3) | (i_cmd_dest == LP_SRC) |
                  (({1'b0, i_cmd_dest} >= LP_NC) & ~w_bcast_legal);
  assign w_push = w_take & ~w_bad;

  always_comb begin
    w_state_nxt = r_state;
    w_dest_nxt  = r_msg_dest;
    w_type_nxt  = r_msg_type;
    w_load      = 1'b0;
    w_sent_inc  = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) w_load = 1'b1;
      ST_SEND: begin
        if (i_msg_accept) begin
          w_sent_inc = 1'b1;
          if (!w_empty) w_load = 1'b1;
          else          w_state_nxt = ST_IDLE;
        end
      end
`ifdef DBG_BCAST_EN
      ST_BCAST: begin
        if (i_msg_accept) begin
          w_sent_inc = 1'b1;
          if (!w_bcast_last) w_dest_nxt = w_dest_step[3:0];
          else if (!w_empty) w_load = 1'b1;
          else               w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    // Loading the head on the accepting edge gives back-to-back messages.
    if (w_load) begin
      w_type_nxt = w_head[5:4];
`ifdef DBG_BCAST_EN
      if (w_head[3:0] == 4'hF) begin
        w_dest_nxt  = LP_FIRST;
        w_state_nxt = ST_BCAST;
      end else begin
        w_dest_nxt  = w_head[3:0];
        w_state_nxt = ST_SEND;
      end
`else
      w_dest_nxt  = w_head[3:0];
      w_state_nxt = ST_SEND;
`endif
    end
  end

  assign w_pop = w_load;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_msg_dest   <= '0;
      r_msg_type   <= '0;
      r_bad_cmd    <= 1'b0;
      r_sent_count <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_msg_dest <= w_dest_nxt;
      r_msg_type <= w_type_nxt;
      r_bad_cmd  <= w_take & w_bad;
      if (w_sent_inc) r_sent_count <= r_sent_count + 16'd1;
      if (w_push)     r_wr_ptr     <= r_wr_ptr + AW'(1);
      if (w_pop)      r_rd_ptr     <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd_type, i_cmd_dest};
  end

  assign o_cmd_ready  = ~w_full;
  assign o_msg_valid  = (r_state != ST_IDLE);
  assign o_msg_dest   = r_msg_dest;
  assign o_msg_src    = LP_SRC;
  assign o_msg_type   = {2'b00, r_msg_type};
  assign o_bad_cmd    = r_bad_cmd;
  assign o_idle       = w_empty & (r_state == ST_IDLE);
  assign o_sent_count = r_sent_count;

endmodule
